// File: rtl/lab3_rsd_pkg.sv
// Shared types, vector table and reference function for the lab3_rsd_p1 gate self-test.
package lab3_rsd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned NUM_VEC = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned FCNT_W  = 3;
  localparam logic [FCNT_W-1:0] FCNT_MAX = 3'd7;

  // Gray-ordered {a,b} stimulus
  localparam logic [1:0] VEC_AB [NUM_VEC] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic logic exp_y(input logic a, input logic b);
    return ~a & b;
  endfunction

endpackage

// File: rtl/lab3_rsd_hold_timer.sv
// Per-vector hold down-counter; expire is high during the last hold cycle.
module lab3_rsd_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Load starts a new hold window; expire is registered one cycle ahead of zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else if (load) begin
      cnt    <= CNT_INIT;
      expire <= (CNT_INIT == '0);
    end else if (cnt != '0) begin
      cnt    <= cnt - CNT_W'(1);
      expire <= (cnt == CNT_W'(1));
    end
  end

endmodule

// File: rtl/lab3_rsd_p1_bist.sv
// BIST sequencer for the Y = ~A & B gate: walks four Gray-ordered vectors and scores y.
// Optional continuous looping over the vector set is enabled with LAB3_BIST_LOOP_EN.
module lab3_rsd_p1_bist
  import lab3_rsd_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef LAB3_BIST_LOOP_EN
  input  logic       loop,
`endif
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] fail_cnt,
  output logic [3:0] fail_vec
);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt_c;
  logic [FCNT_W-1:0] fail_cnt_nxt_c;
  logic              expire;
  logic              load_c;
  logic              loop_c;
  logic              mism_c;
  logic              last_c;

`ifdef LAB3_BIST_LOOP_EN
  assign loop_c = loop;
`else
  assign loop_c = 1'b0;
`endif

  // Sample scoring and timer reload
  always_comb begin
    idx_nxt_c      = idx + IDX_W'(1);
    last_c         = (idx == IDX_W'(NUM_VEC - 1));
    mism_c         = (dut_y != exp_y(dut_a, dut_b));
    fail_cnt_nxt_c = fail_cnt;
    if (mism_c && (fail_cnt != FCNT_MAX)) begin
      fail_cnt_nxt_c = fail_cnt + FCNT_W'(1);
    end
    load_c = (state == APPLY) ? expire : start;
  end

  lab3_rsd_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_c),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      dut_a    <= 1'b0;
      dut_b    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_cnt <= '0;
      fail_vec <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= APPLY;
            idx            <= '0;
            {dut_a, dut_b} <= VEC_AB[0];
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_cnt       <= '0;
            fail_vec       <= '0;
          end
        end
        APPLY: begin
          if (expire) begin
            fail_cnt <= fail_cnt_nxt_c;
            if (mism_c) begin
              fail_vec[idx] <= 1'b1;
            end
            // Last vector ends the pass unless looping is requested
            if (last_c && !loop_c) begin
              state          <= DONE;
              idx            <= '0;
              {dut_a, dut_b} <= 2'b00;
              busy           <= 1'b0;
              done           <= 1'b1;
              pass           <= (fail_cnt_nxt_c == '0);
            end else begin
              idx            <= idx_nxt_c;
              {dut_a, dut_b} <= VEC_AB[idx_nxt_c];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lab3_rsd_p1_bist.sv
// Self-checking bench for lab3_rsd_p1_bist: cycle model plus directed literal checks.
module tb_lab3_rsd_p1_bist;

  localparam int H = 10;
  localparam logic [1:0] AB_LIT [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, dut_y, dut_a, dut_b, busy, done, pass;
  logic [2:0] fail_cnt;
  logic [3:0] fail_vec;
  logic       start1, y1, a1, b1, busy1, done1, pass1;
  logic [2:0] fcnt1;
  logic [3:0] fvec1;
`ifdef LAB3_BIST_LOOP_EN
  logic       loop;
`endif

  int mode;
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Gate under test: 0 good, 1 stuck-at-0, 2 OR gate, 3 stuck-at-1
  function automatic logic gate_y(input int md, input logic a, input logic b);
    case (md)
      1:       return 1'b0;
      2:       return a | b;
      3:       return 1'b1;
      default: return ~a & b;
    endcase
  endfunction

  always_comb dut_y = gate_y(mode, dut_a, dut_b);
  assign y1 = ~a1 & b1;

  lab3_rsd_p1_bist #(.HOLD_CYCLES(H)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef LAB3_BIST_LOOP_EN
    .loop(loop),
`endif
    .dut_y(dut_y), .dut_a(dut_a), .dut_b(dut_b), .busy(busy), .done(done),
    .pass(pass), .fail_cnt(fail_cnt), .fail_vec(fail_vec)
  );

  lab3_rsd_p1_bist #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef LAB3_BIST_LOOP_EN
    .loop(1'b0),
`endif
    .dut_y(y1), .dut_a(a1), .dut_b(b1), .busy(busy1), .done(done1),
    .pass(pass1), .fail_cnt(fcnt1), .fail_vec(fvec1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: m_e counts edges since the start edge while running
  int         m_e;
  bit         m_run, m_done;
  int         m_fcnt;
  logic [3:0] m_fvec;

  function automatic bit vec_bad(input int v);
    logic [1:0] ab;
    ab = AB_LIT[v];
    return gate_y(mode, ab[1], ab[0]) != (~ab[1] & ab[0]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_e    <= 0;
      m_fcnt <= 0;
      m_fvec <= 4'b0000;
    end else if (m_run) begin
      if (((m_e + 1) % H == 0) && vec_bad(m_e / H)) begin
        m_fvec[2'(m_e / H)] <= 1'b1;
        if (m_fcnt < 7) m_fcnt <= m_fcnt + 1;
      end
      if (m_e + 1 == 4 * H) begin
        m_e <= 0;
`ifdef LAB3_BIST_LOOP_EN
        if (!loop) begin
          m_run  <= 1'b0;
          m_done <= 1'b1;
        end
`else
        m_run  <= 1'b0;
        m_done <= 1'b1;
`endif
      end else begin
        m_e <= m_e + 1;
      end
    end else if (start) begin
      m_run  <= 1'b1;
      m_done <= 1'b0;
      m_e    <= 0;
      m_fcnt <= 0;
      m_fvec <= 4'b0000;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(busy), int'(m_run));
      check("done", int'(done), int'(m_done));
      check("pass", int'(pass), int'(m_done && (m_fcnt == 0)));
      check("fail_cnt", int'(fail_cnt), m_fcnt);
      check("fail_vec", int'(fail_vec), int'(m_fvec));
      check("ab", int'({dut_a, dut_b}), int'(m_run ? AB_LIT[m_e / H] : 2'b00));
    end
  end

  // Start one run; optional busy re-start, mid-run reset and loop release points
  task automatic run(input int restart_at, input int rst_at, input int loop_off_at,
                     output int lat);
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      start = (n == restart_at);
`ifdef LAB3_BIST_LOOP_EN
      if (n == loop_off_at) loop = 1'b0;
`else
      if (loop_off_at != 0 && n == loop_off_at) check("no_loop_build", 0, 0 + 1);
`endif
      if (n == 1) begin
        check("clr_done", int'(done), 0);
        check("clr_fail_cnt", int'(fail_cnt), 0);
        check("clr_fail_vec", int'(fail_vec), 0);
      end
      if ((n == 1 || n == 11 || n == 21 || n == 31) && (rst_at == 0 || n < rst_at))
        check("ab_lit", int'({dut_a, dut_b}), int'(AB_LIT[(n - 1) / 10]));
      if (n == rst_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ab", int'({dut_a, dut_b}), 0);
        check("rst_fail_cnt", int'(fail_cnt), 0);
        check("rst_fail_vec", int'(fail_vec), 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    rst_n  = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    mode   = 0;
`ifdef LAB3_BIST_LOOP_EN
    loop   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_pass", int'(pass), 0);
    check("reset_ab", int'({dut_a, dut_b}), 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    mode = 0;
    run(0, 0, 0, lat);
    check("good_latency", lat, 41);
    check("good_pass", int'(pass), 1);
    check("good_fail_vec", int'(fail_vec), 0);

    mode = 1;
    run(0, 0, 0, lat);
    check("sa0_latency", lat, 41);
    check("sa0_pass", int'(pass), 0);
    check("sa0_fail_cnt", int'(fail_cnt), 1);
    check("sa0_fail_vec", int'(fail_vec), 4'b0010);

    mode = 2;
    run(15, 0, 0, lat);
    check("or_busy_start_latency", lat, 41);
    check("or_pass", int'(pass), 0);
    check("or_fail_cnt", int'(fail_cnt), 2);
    check("or_fail_vec", int'(fail_vec), 4'b1100);

    mode = 0;
    run(0, 0, 0, lat);
    check("rerun_pass", int'(pass), 1);
    check("rerun_fail_cnt", int'(fail_cnt), 0);

    run(0, 20, 0, lat);
    check("reset_abort_no_done", lat, -1);
    run(0, 0, 0, lat);
    check("post_reset_latency", lat, 41);
    check("post_reset_pass", int'(pass), 1);

    // HOLD_CYCLES=1 instance: new vector every clock
    @(negedge clk);
    start1 = 1'b1;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      start1 = 1'b0;
      if (n <= 4) check("h1_ab", int'({a1, b1}), int'(AB_LIT[n - 1]));
      if (done1) begin
        lat = n;
        break;
      end
    end
    check("h1_latency", lat, 5);
    check("h1_pass", int'(pass1), 1);
    check("h1_fail_vec", int'(fvec1), 0);

`ifdef LAB3_BIST_LOOP_EN
    mode = 3;
    loop = 1'b1;
    run(0, 0, 85, lat);
    check("loop_latency", lat, 121);
    check("loop_fail_cnt", int'(fail_cnt), 7);
    check("loop_fail_vec", int'(fail_vec), 4'b1101);
    check("loop_pass", int'(pass), 0);
    mode = 0;
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
